// File: rtl/tinyqv_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// tinyqv_mem_arbiter_if
//
// Purpose: bus between the memory arbiter and the downstream memory
// controller. One transaction is launched with mem_start; mem_addr,
// mem_write and mem_size stay stable while the arbiter owns the bus.
//
// Signals:
//   mem_start       arbiter -> ctrl   one-cycle launch pulse
//   mem_addr        arbiter -> ctrl   byte address (ADDR_BITS)
//   mem_write       arbiter -> ctrl   1 = store
//   mem_size        arbiter -> ctrl   0 byte, 1 half, 2 word
//   mem_stop        arbiter -> ctrl   abort the current stream
//   mem_busy        ctrl -> arbiter   transaction in progress
//   mem_data_ready  ctrl -> arbiter   data beat valid
//   mem_done        ctrl -> arbiter   transaction finished (one-cycle pulse)
//
// Modports: master (arbiter side), slave (controller side).
// ---------------------------------------------------------------------------
interface tinyqv_mem_arbiter_if #(
    parameter int ADDR_BITS = 24
);
    logic                 mem_start;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_write;
    logic [1:0]           mem_size;
    logic                 mem_stop;
    logic                 mem_busy;
    logic                 mem_data_ready;
    logic                 mem_done;

    modport master (
        output mem_start, mem_addr, mem_write, mem_size, mem_stop,
        input  mem_busy, mem_data_ready, mem_done
    );

    modport slave (
        input  mem_start, mem_addr, mem_write, mem_size, mem_stop,
        output mem_busy, mem_data_ready, mem_done
    );
endinterface

// File: rtl/tinyqv_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tinyqv_mem_arbiter
//
// Purpose: shares one memory controller between the instruction fetch unit
// (streaming reads) and the load/store unit. Loads/stores normally win; after
// a data transaction that finished while a fetch was waiting, the next grant
// goes to the fetch (fair_instr). A load/store arriving while the bus is
// owned is held in a one-deep pending slot.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   instr_req/instr_addr/instr_stop fetch request, start address, abandon
//   instr_ready                     data beat for fetch owner
//   data_req/data_addr/data_write/data_size   load/store request
//   data_ready                      data beat for load/store owner
//   data_busy                       load/store accepted, not yet complete
//   mem                             tinyqv_mem_arbiter_if.master to controller
//
// Build option: define TINYQV_ARB_PREEMPT_EN to let a new load/store abort
// an in-flight fetch stream instead of waiting for it to finish.
// ---------------------------------------------------------------------------
module tinyqv_mem_arbiter #(
    parameter int ADDR_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic                 instr_req,
    input  logic [ADDR_BITS-1:0] instr_addr,
    input  logic                 instr_stop,
    output logic                 instr_ready,

    input  logic                 data_req,
    input  logic [ADDR_BITS-1:0] data_addr,
    input  logic                 data_write,
    input  logic [1:0]           data_size,
    output logic                 data_ready,
    output logic                 data_busy,

    tinyqv_mem_arbiter_if.master mem
);
    typedef enum logic [1:0] {IDLE, INSTR, DATA, STOP} state_t;

    // Counter value seen on the 15th busy cycle spent in STOP.
    localparam logic [3:0] STOP_LAST = 4'd14;

    state_t               state, state_next;
    logic                 pending;
    logic [ADDR_BITS-1:0] pend_addr;
    logic                 pend_write;
    logic [1:0]           pend_size;
    logic                 fair_instr;
    logic [3:0]           stop_cnt;
    logic [ADDR_BITS-1:0] addr_q;
    logic                 write_q;
    logic [1:0]           size_q;

    logic                 data_grant;
    logic                 instr_grant;
    logic                 stop_out;
    logic                 data_avail;
    logic [ADDR_BITS-1:0] grant_addr;
    logic                 grant_write;
    logic [1:0]           grant_size;

    assign data_avail = pending | data_req;

    always_comb begin
        state_next  = state;
        data_grant  = 1'b0;
        instr_grant = 1'b0;
        stop_out    = 1'b0;
        case (state)
            IDLE: begin
                // Grants are gated by rstn so mem_start is low throughout reset.
                if (rstn) begin
                    if (data_avail && !(fair_instr && instr_req)) begin
                        data_grant = 1'b1;
                        state_next = DATA;
                    end else if (instr_req) begin
                        instr_grant = 1'b1;
                        state_next  = INSTR;
                    end
                end
            end
            INSTR: begin
                // A finishing fetch needs no abort even if the branch arrives too.
                if (mem.mem_done) begin
                    state_next = IDLE;
                end else if (instr_stop) begin
                    stop_out   = 1'b1;
                    state_next = STOP;
                end
`ifdef TINYQV_ARB_PREEMPT_EN
                else if (data_req && !pending) begin
                    stop_out   = 1'b1;
                    state_next = STOP;
                end
`endif
            end
            DATA: begin
                if (mem.mem_done) begin
                    state_next = IDLE;
                end
            end
            STOP: begin
                if (!mem.mem_busy) begin
                    state_next = IDLE;
                end else begin
                    stop_out = 1'b1;
                    // Controller never released the bus: give up and go idle.
                    if (stop_cnt == STOP_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_addr  = instr_addr;
        grant_write = 1'b0;
        grant_size  = 2'd2;
        if (data_grant) begin
            grant_addr  = pending ? pend_addr  : data_addr;
            grant_write = pending ? pend_write : data_write;
            grant_size  = pending ? pend_size  : data_size;
        end
    end

    // Attributes are forwarded combinationally on the launch cycle so they
    // are valid alongside mem_start, then held from the latched copy.
    assign mem.mem_start = data_grant | instr_grant;
    assign mem.mem_addr  = mem.mem_start ? grant_addr  : addr_q;
    assign mem.mem_write = mem.mem_start ? grant_write : write_q;
    assign mem.mem_size  = mem.mem_start ? grant_size  : size_q;
    assign mem.mem_stop  = stop_out;

    assign instr_ready = (state == INSTR) & mem.mem_data_ready;
    assign data_ready  = (state == DATA)  & mem.mem_data_ready;
    assign data_busy   = pending | data_grant | ((state == DATA) & ~mem.mem_done);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            pending    <= 1'b0;
            pend_addr  <= '0;
            pend_write <= 1'b0;
            pend_size  <= 2'd0;
            fair_instr <= 1'b0;
            stop_cnt   <= 4'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 2'd0;
        end else begin
            state <= state_next;

            if (mem.mem_start) begin
                addr_q  <= grant_addr;
                write_q <= grant_write;
                size_q  <= grant_size;
            end

            // Any load/store not granted on arrival is parked; a second one
            // while the slot is full is dropped.
            if (data_grant) begin
                pending <= 1'b0;
            end else if (data_req && !pending) begin
                pending    <= 1'b1;
                pend_addr  <= data_addr;
                pend_write <= data_write;
                pend_size  <= data_size;
            end

            if (instr_grant) begin
                fair_instr <= 1'b0;
            end else if (state == DATA && mem.mem_done && instr_req) begin
                fair_instr <= 1'b1;
            end

            // Held at zero outside STOP, so it starts from zero on every entry.
            if (state != STOP) begin
                stop_cnt <= 4'd0;
            end else if (mem.mem_busy) begin
                stop_cnt <= stop_cnt + 4'd1;
            end
        end
    end
endmodule
